// File: rtl/bootram_arbiter_pkg.sv
// Shared types and constants for the two-requester boot RAM arbiter.
// Optional write protection of the CPU port is selected with BOOTRAM_WP_EN.
package bootram_pkg;

   localparam int BOOTRAM_ADDR_W = 11;
   localparam int BOOTRAM_LANES  = 4;

   typedef logic [1:0] state_t;
   localparam state_t IDLE   = 2'd0;
   localparam state_t ACCESS = 2'd1;
   localparam state_t DONE   = 2'd2;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_LDR = 1'b1
   } grant_t;

   function automatic grant_t other_grant(input grant_t g);
      return (g == GNT_CPU) ? GNT_LDR : GNT_CPU;
   endfunction

endpackage

// File: rtl/bootram_arbiter_if.sv
// Native memory request port: valid/addr/wdata/wstrb in, ready/rdata back.
// One instance per requester (CPU bus, boot loader).
interface bootram_arbiter_if #(
   parameter int ADDR_W = 11
) ();
   logic              valid;
   logic [ADDR_W+1:0] addr;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              ready;
   logic [31:0]       rdata;

   modport master (output valid, addr, wdata, wstrb, input ready, rdata);
   modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/bootram_arbiter_rr_arb.sv
// Two-way round-robin arbiter: a lone requester wins outright, a tie goes to
// whoever was not granted last.
module bootram_rr_arb
   import bootram_pkg::*;
(
   input  logic [1:0] req,
   input  grant_t     last_grant,
   output grant_t     grant
);

   always_comb begin
      grant = other_grant(last_grant);
      case (req)
         2'b01:   grant = GNT_CPU;
         2'b10:   grant = GNT_LDR;
         default: ;
      endcase
   end

endmodule

// File: rtl/bootram_arbiter.sv
// Boot RAM arbiter: round-robin shares four 2Kx8 byte lanes between the CPU and
// the boot loader. Define BOOTRAM_WP_EN to turn CPU writes into no-op accesses.
module bootram_arbiter
   import bootram_pkg::*;
#(
   parameter int ADDR_W = BOOTRAM_ADDR_W,
   parameter int LANES  = BOOTRAM_LANES
) (
   input  logic               clk,
   input  logic               reset,
   bootram_arbiter_if.slave   cpu,
   bootram_arbiter_if.slave   ldr,
   output logic [LANES-1:0]   ram_ce,
   output logic [LANES-1:0]   ram_wre,
   output logic               ram_oce,
   output logic [ADDR_W-1:0]  ram_ad,
   output logic [8*LANES-1:0] ram_din,
   input  logic [8*LANES-1:0] ram_dout,
   output logic               busy,
   output logic               wp_err
);

   state_t state_reg;
   grant_t last_grant_reg;
   grant_t grant_reg;
   logic   is_read_reg;

   grant_t            arb_grant;
   logic [1:0]        req;
   logic [ADDR_W+1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic [3:0]        sel_wstrb;
   logic              sel_is_read;
   logic              wp_block_next;
   logic [LANES-1:0]  lane_ce_next;
   logic [LANES-1:0]  lane_we_next;
   logic              done;
   logic              unused_addr_bits;

   assign req = {ldr.valid, cpu.valid};

   bootram_rr_arb u_rr_arb (
      .req        (req),
      .last_grant (last_grant_reg),
      .grant      (arb_grant)
   );

   assign sel_addr    = (arb_grant == GNT_CPU) ? cpu.addr  : ldr.addr;
   assign sel_wdata   = (arb_grant == GNT_CPU) ? cpu.wdata : ldr.wdata;
   assign sel_wstrb   = (arb_grant == GNT_CPU) ? cpu.wstrb : ldr.wstrb;
   assign sel_is_read = (sel_wstrb == 4'h0);

   // Byte offset bits play no part in a word-wide access.
   assign unused_addr_bits = ^sel_addr[1:0];

`ifdef BOOTRAM_WP_EN
   logic wp_reg;

   assign wp_block_next = (arb_grant == GNT_CPU) && !sel_is_read;

   always_ff @(posedge clk) begin
      if (reset) begin
         wp_reg <= 1'b0;
      end else if (state_reg == IDLE && (|req)) begin
         wp_reg <= wp_block_next;
      end
   end

   assign wp_err = done && wp_reg;
`else
   assign wp_block_next = 1'b0;
   assign wp_err        = 1'b0;
`endif

   // A read enables every lane; a write enables only its strobed lanes.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_we_next[gi] = ~wp_block_next & sel_wstrb[gi];
      assign lane_ce_next[gi] = ~wp_block_next & (sel_is_read | sel_wstrb[gi]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         last_grant_reg <= GNT_LDR;
         grant_reg      <= GNT_CPU;
         is_read_reg    <= 1'b0;
         ram_ce         <= '0;
         ram_wre        <= '0;
         ram_ad         <= '0;
         ram_din        <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (|req) begin
                  grant_reg      <= arb_grant;
                  last_grant_reg <= arb_grant;
                  is_read_reg    <= sel_is_read;
                  ram_ad         <= sel_addr[ADDR_W+1:2];
                  ram_din        <= sel_wdata;
                  ram_ce         <= lane_ce_next;
                  ram_wre        <= lane_we_next;
                  state_reg      <= ACCESS;
               end
            end
            ACCESS: begin
               ram_ce    <= '0;
               ram_wre   <= '0;
               state_reg <= DONE;
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               ram_ce    <= '0;
               ram_wre   <= '0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Lane data arrives during DONE, one cycle after the read strobe.
   assign done      = (state_reg == DONE);
   assign busy      = (state_reg != IDLE);
   assign ram_oce   = 1'b1;
   assign cpu.ready = done && (grant_reg == GNT_CPU);
   assign ldr.ready = done && (grant_reg == GNT_LDR);
   assign cpu.rdata = (cpu.ready && is_read_reg) ? ram_dout : 32'h0;
   assign ldr.rdata = (ldr.ready && is_read_reg) ? ram_dout : 32'h0;

endmodule

// File: tb/tb_bootram_arbiter.sv
// Self-checking bench for bootram_arbiter: directed cases plus random rounds
// scored against a transaction-level memory and fairness model.
module tb_bootram_arbiter;

   localparam int AW = 11;
`ifdef BOOTRAM_WP_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif

   typedef struct packed {
      logic [AW+1:0] addr;
      logic [31:0]   wdata;
      logic [3:0]    wstrb;
   } op_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   ram_ce, ram_wre;
   logic         ram_oce;
   logic [AW-1:0] ram_ad;
   logic [31:0]  ram_din;
   logic [31:0]  ram_dout;
   logic         busy, wp_err;

   bootram_arbiter_if #(.ADDR_W(AW)) cpu_bus ();
   bootram_arbiter_if #(.ADDR_W(AW)) ldr_bus ();

   bootram_arbiter #(.ADDR_W(AW), .LANES(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .cpu      (cpu_bus),
      .ldr      (ldr_bus),
      .ram_ce   (ram_ce),
      .ram_wre  (ram_wre),
      .ram_oce  (ram_oce),
      .ram_ad   (ram_ad),
      .ram_din  (ram_din),
      .ram_dout (ram_dout),
      .busy     (busy),
      .wp_err   (wp_err)
   );

   always #5 clk = ~clk;

   // Four byte-lane RAMs in bypass read mode.
   logic [31:0] ram_mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (ram_ce[k]) begin
            if (ram_wre[k]) ram_mem[ram_ad][8*k +: 8] <= ram_din[8*k +: 8];
            else            ram_dout[8*k +: 8]        <= ram_mem[ram_ad][8*k +: 8];
         end
      end
   end

   // Reference model state.
   logic [31:0] ref_mem [0:(1<<AW)-1];
   bit          model_last;   // 0 = CPU, 1 = loader

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h expected=%h", tag, got, exp);
   endtask

   function automatic logic [31:0] strb_mask(input logic [3:0] s);
      return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
   endfunction

   task automatic drive(input bit who, input bit v, input op_t op);
      if (who == 1'b0) begin
         cpu_bus.valid = v; cpu_bus.addr = op.addr; cpu_bus.wdata = op.wdata; cpu_bus.wstrb = op.wstrb;
      end else begin
         ldr_bus.valid = v; ldr_bus.addr = op.addr; ldr_bus.wdata = op.wdata; ldr_bus.wstrb = op.wstrb;
      end
   endtask

   // Entered and left at a negedge with the DUT in IDLE.
   task automatic run_round(input bit c_en, input op_t c_op, input bit l_en, input op_t l_op);
      bit order [2];
      int n;
      if (c_en && l_en) begin
         order[0] = ~model_last; order[1] = model_last; n = 2;
      end else begin
         order[0] = l_en; order[1] = 1'b0; n = 1;
      end
      if (c_en) drive(1'b0, 1'b1, c_op);
      if (l_en) drive(1'b1, 1'b1, l_op);
      for (int i = 0; i < n; i++) begin
         bit          who     = order[i];
         op_t         op      = who ? l_op : c_op;
         bit          is_rd   = (op.wstrb == 4'h0);
         bit          blocked = WP && (who == 1'b0) && !is_rd;
         logic [10:0] word    = op.addr[AW+1:2];
         logic [31:0] exp_rd;
         logic [31:0] got_rd;
         logic [31:0] oth_rd;
         if (i > 0) begin
            @(posedge clk); @(negedge clk);
            check("gap_busy", {31'b0, busy}, 32'h0);
         end
         @(posedge clk); @(negedge clk);
         check("acc_busy", {31'b0, busy}, 32'h1);
         check("acc_ad", {21'b0, ram_ad}, {21'b0, word});
         check("acc_ce", {28'b0, ram_ce}, blocked ? 32'h0 : (is_rd ? 32'hF : {28'b0, op.wstrb}));
         check("acc_wre", {28'b0, ram_wre}, (blocked || is_rd) ? 32'h0 : {28'b0, op.wstrb});
         check("acc_ready", {30'b0, cpu_bus.ready, ldr_bus.ready}, 32'h0);
         if (!is_rd && !blocked)
            check("acc_din", ram_din & strb_mask(op.wstrb), op.wdata & strb_mask(op.wstrb));
         @(posedge clk); @(negedge clk);
         exp_rd = is_rd ? ref_mem[word] : 32'h0;
         got_rd = who ? ldr_bus.rdata : cpu_bus.rdata;
         oth_rd = who ? cpu_bus.rdata : ldr_bus.rdata;
         check("done_ready", {30'b0, cpu_bus.ready, ldr_bus.ready}, who ? 32'h1 : 32'h2);
         check("done_rdata", got_rd, exp_rd);
         check("other_rdata", oth_rd, 32'h0);
         check("done_wp_err", {31'b0, wp_err}, {31'b0, blocked});
         check("done_ce", {28'b0, ram_ce}, 32'h0);
         if (!is_rd && !blocked)
            ref_mem[word] = (ref_mem[word] & ~strb_mask(op.wstrb)) | (op.wdata & strb_mask(op.wstrb));
         model_last = who;
         $display("txn %s %s addr=%h wdata=%h wstrb=%h rdata=%h%s", who ? "ldr" : "cpu",
                  is_rd ? "rd" : "wr", op.addr, op.wdata, op.wstrb, got_rd, blocked ? " wp" : "");
         drive(who, 1'b0, op);
      end
      @(posedge clk); @(negedge clk);
   endtask

   function automatic op_t mk(input logic [AW+1:0] a, input logic [31:0] d, input logic [3:0] s);
      op_t o;
      o.addr = a; o.wdata = d; o.wstrb = s;
      return o;
   endfunction

   function automatic op_t rand_op();
      op_t         o;
      logic [10:0] w;
      case ($urandom_range(0, 5))
         0:       w = 11'd0;
         1:       w = 11'd4;
         2:       w = 11'd5;
         3:       w = 11'h7FF;
         default: w = 11'($urandom_range(0, 2047));
      endcase
      o.addr  = {w, 2'($urandom_range(0, 3))};
      o.wdata = $urandom;
      o.wstrb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      return o;
   endfunction

   op_t nop_op;

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         ram_mem[i] = 32'h0;
         ref_mem[i] = 32'h0;
      end
      ram_dout   = 32'h0;
      nop_op     = mk(13'h0, 32'h0, 4'h0);
      model_last = 1'b1;
      drive(1'b0, 1'b0, nop_op);
      drive(1'b1, 1'b0, nop_op);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_oce", {31'b0, ram_oce}, 32'h1);
      check("rst_ce_wre", {24'b0, ram_ce, ram_wre}, 32'h0);
      check("rst_ad", {21'b0, ram_ad}, 32'h0);
      check("rst_din", ram_din, 32'h0);
      check("rst_ready", {28'b0, cpu_bus.ready, ldr_bus.ready, wp_err, 1'b0}, 32'h0);
      reset = 1'b0;
      @(posedge clk); @(negedge clk);

      // Simultaneous requesters from reset alternate, CPU first.
      run_round(1'b1, mk(13'h020, 32'h0, 4'h0), 1'b1, mk(13'h024, 32'hA5A5A5A5, 4'hF));
      run_round(1'b1, mk(13'h024, 32'h0, 4'h0), 1'b1, mk(13'h020, 32'h0, 4'h0));

      run_round(1'b0, nop_op, 1'b1, mk(13'h010, 32'hDEADBEEF, 4'hF));
      run_round(1'b1, mk(13'h010, 32'h0, 4'h0), 1'b0, nop_op);
      run_round(1'b0, nop_op, 1'b1, mk(13'h010, 32'h005A0000, 4'b0100));
      run_round(1'b1, mk(13'h012, 32'h0, 4'h0), 1'b0, nop_op);
      run_round(1'b0, nop_op, 1'b1, mk(13'h1FFC, 32'h12345678, 4'hF));
      run_round(1'b1, mk(13'h1FFC, 32'h0, 4'h0), 1'b0, nop_op);
      run_round(1'b1, mk(13'h010, 32'hFFFFFFFF, 4'hF), 1'b0, nop_op);
      run_round(1'b0, nop_op, 1'b1, mk(13'h010, 32'h0, 4'h0));

      // Reset during ACCESS of a CPU read abandons it without a ready pulse.
      drive(1'b0, 1'b1, mk(13'h010, 32'h0, 4'h0));
      @(posedge clk); @(negedge clk);
      check("pre_rst_busy", {31'b0, busy}, 32'h1);
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      check("mid_rst_busy", {31'b0, busy}, 32'h0);
      check("mid_rst_ready", {30'b0, cpu_bus.ready, ldr_bus.ready}, 32'h0);
      check("mid_rst_ce", {28'b0, ram_ce}, 32'h0);
      reset = 1'b0;
      drive(1'b0, 1'b0, nop_op);
      model_last = 1'b1;
      @(posedge clk); @(negedge clk);
      check("post_rst_ready", {30'b0, cpu_bus.ready, ldr_bus.ready}, 32'h0);
      run_round(1'b0, nop_op, 1'b1, mk(13'h010, 32'h0, 4'h0));

      for (int r = 0; r < 40; r++) begin
         bit c_en = 1'($urandom_range(0, 1));
         bit l_en = 1'($urandom_range(0, 1));
         if (!c_en && !l_en) l_en = 1'b1;
         run_round(c_en, rand_op(), l_en, rand_op());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
